// File: rtl/phase_seq_pkg.sv
// -----------------------------------------------------------------------------
// phase_seq_pkg
// Shared types for the phase sequencer:
//   state_t      - sequencer state codes, also driven out on the state port
//   status_t     - per-unit 2-bit status codes reported by the sub-units
//   err_cause_t  - reason recorded when the sequencer enters ERR
// -----------------------------------------------------------------------------
package phase_seq_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_CALC = 3'd1,
        S_DISP = 3'd2,
        S_LAST = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READY = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_FAULT   = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } err_cause_t;

endpackage

// File: rtl/phase_seq_watchdog.sv
// -----------------------------------------------------------------------------
// phase_seq_watchdog
// Counts cycles spent in a single waiting phase. The count returns to zero
// whenever clear is high or run is low, so it always measures "edges since the
// current phase was entered". expired is high while the count sits at
// TIMEOUT_CYC-1, i.e. the next edge is the TIMEOUT_CYC-th edge in the phase.
//
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset (count to 0)
//   clear   - a phase change is being taken on this edge
//   run     - the owner is in a phase that is watched
//   expired - limit reached, combinational from the count register and run
// -----------------------------------------------------------------------------
module phase_seq_watchdog #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == LIMIT);

endmodule

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Steps a group of sub-units through INIT -> CALC -> DISP -> LAST, issuing a
// one-cycle start pulse to the units involved in each phase and moving to ERR
// on any unit fault. Optional watchdog: define PHASE_SEQ_TIMEOUT_EN to abort a
// CALC or DISP phase that lasts TIMEOUT_CYC cycles (err_cause = timeout).
// Without the macro no counter exists and CALC/DISP may wait forever.
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset, overrides everything
//   status    - 2 bits per unit, unit i at [2i+1:2i] (idle/ready/done/fault)
//   restart   - abort CALC/DISP, leave LAST, or clear ERR (when fault-free)
//   state     - current state code (registered)
//   start     - one-cycle start pulse per unit, first cycle of CALC/DISP only
//   done      - high while in LAST
//   err       - high while in ERR
//   err_cause - 00 none, 01 unit fault, 10 timeout
//
// Transition priority outside ERR: fault, timeout, restart, normal progress.
// All outputs are registers; inputs affect outputs only after the next edge.
// -----------------------------------------------------------------------------
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int                 N_UNITS     = 3,
    parameter logic [N_UNITS-1:0] CALC_MASK   = N_UNITS'(3'b011),
    parameter logic [N_UNITS-1:0] DISP_MASK   = N_UNITS'(3'b100),
    parameter int                 TIMEOUT_CYC = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*N_UNITS-1:0]   status,
    input  logic                   restart,
    output logic [2:0]             state,
    output logic [N_UNITS-1:0]     start,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             err_cause
);

    state_t               state_q;
    logic [N_UNITS-1:0]   start_q;
    logic                 done_q;
    logic                 err_q;
    err_cause_t           cause_q;

    // Per-unit status decode.
    logic [N_UNITS-1:0] is_ready;
    logic [N_UNITS-1:0] is_done;
    logic [N_UNITS-1:0] is_fault;

    always_comb begin
        is_ready = '0;
        is_done  = '0;
        is_fault = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            is_ready[i] = (status[2*i +: 2] == ST_READY);
            is_done[i]  = (status[2*i +: 2] == ST_DONE);
            is_fault[i] = (status[2*i +: 2] == ST_FAULT);
        end
    end

    logic all_ready;
    logic any_fault;
    logic calc_done;
    logic disp_done;
    logic timeout;

    assign all_ready = &is_ready;
    assign any_fault = |is_fault;
    // Units outside the mask are treated as finished.
    assign calc_done = &(is_done | ~CALC_MASK);
    assign disp_done = &(is_done | ~DISP_MASK);

`ifdef PHASE_SEQ_TIMEOUT_EN
    logic wd_run;
    logic wd_clear;

    assign wd_run   = (state_q == S_CALC) || (state_q == S_DISP);
    // Every way out of CALC/DISP other than the timeout itself; leaving via
    // timeout drops run, which clears the count anyway.
    assign wd_clear = any_fault || restart
                    || ((state_q == S_CALC) && calc_done)
                    || ((state_q == S_DISP) && disp_done);

    phase_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .run     (wd_run),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            start_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            // Pulses only ever last the single cycle after the entering edge.
            start_q <= '0;
            if (state_q == S_ERR) begin
                if (restart && !any_fault) begin
                    state_q <= S_INIT;
                    err_q   <= 1'b0;
                    cause_q <= CAUSE_NONE;
                end
            end else if (any_fault) begin
                state_q <= S_ERR;
                done_q  <= 1'b0;
                err_q   <= 1'b1;
                cause_q <= CAUSE_FAULT;
            end else if (timeout) begin
                state_q <= S_ERR;
                done_q  <= 1'b0;
                err_q   <= 1'b1;
                cause_q <= CAUSE_TIMEOUT;
            end else if (restart) begin
                state_q <= S_INIT;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_INIT: begin
                        if (all_ready) begin
                            state_q <= S_CALC;
                            start_q <= CALC_MASK;
                        end
                    end
                    S_CALC: begin
                        if (calc_done) begin
                            state_q <= S_DISP;
                            start_q <= DISP_MASK;
                        end
                    end
                    S_DISP: begin
                        if (disp_done) begin
                            state_q <= S_LAST;
                            done_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state     = state_q;
    assign start     = start_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cause = cause_q;

endmodule
